// File: rtl/data_memory_responder_if.sv
// Main data-memory request/response bundle plus the instruction-fetch port.
// The requester drives master; the memory responder sits on slave.
interface data_memory_responder_if;
  logic [31:0] address_main;
  logic [1:0]  width_main;
  logic        read_request_main;
  logic        write_request_main;
  logic [31:0] write_data_main;
  logic [31:0] data_main;
  logic        busy_main;
  logic        error_main;
  logic [31:0] address_fetch;
  logic        fetch_request;
  logic [31:0] data_fetch;

  modport master (
    output address_main, width_main,
    output read_request_main, write_request_main,
    output write_data_main,
    output address_fetch, fetch_request,
    input  data_main, busy_main, error_main,
    input  data_fetch
  );

  modport slave (
    input  address_main, width_main,
    input  read_request_main, write_request_main,
    input  write_data_main,
    input  address_fetch, fetch_request,
    output data_main, busy_main, error_main,
    output data_fetch
  );
endinterface

// File: rtl/data_memory_responder.sv
// Wait-state data RAM responder with byte lanes and a shared fetch port.
// Define MEM_ERROR_EN to fault misaligned/out-of-range accesses.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  data_memory_responder_if.slave bus
);
  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        armed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_width;
  logic        req_wr;
  logic [31:0] data_q;
  logic [31:0] fetch_q;
  logic [31:0] ram [DEPTH_WORDS];

  logic        any_req;
  logic        accept;
  logic        commit;
  logic        is_byte;
  logic        is_half;
  logic        fault;
  logic [31:0] eff_addr;
  logic [1:0]  lane;
  logic [AW-1:0] widx;
  logic [AW-1:0] fidx;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rword;
  logic [31:0] rshift;
  logic [31:0] rdata;
  logic        unused_fetch_lsb;

  assign any_req = bus.read_request_main
                 | bus.write_request_main;
  assign accept  = (state == IDLE) & armed & any_req;
  assign commit  = (state == WAIT) & (cnt == 4'd0);
  assign is_byte = (req_width == 2'b00);
  assign is_half = (req_width == 2'b01);

`ifdef MEM_ERROR_EN
  logic err_q;
  assign eff_addr = req_addr;
  assign fault = (is_half & req_addr[0])
               | (!is_byte && !is_half
                  && req_addr[1:0] != 2'b00)
               | (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign bus.error_main = err_q;

  // Error pulse lives exactly for the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= commit & fault;
  end
`else
  assign fault = 1'b0;
  assign bus.error_main = 1'b0;

  // Misaligned accesses are silently aligned down.
  always_comb begin
    eff_addr = req_addr;
    unique case (1'b1)
      is_byte: eff_addr = req_addr;
      is_half: eff_addr = {req_addr[31:1], 1'b0};
      default: eff_addr = {req_addr[31:2], 2'b00};
    endcase
  end
`endif

  assign lane = eff_addr[1:0];
  assign widx = AW'(eff_addr[31:2] % 30'(DEPTH_WORDS));
  assign fidx =
    AW'(bus.address_fetch[31:2] % 30'(DEPTH_WORDS));
  assign unused_fetch_lsb = ^bus.address_fetch[1:0];

  assign wdata_sh = req_wdata << {lane, 3'b000};
  assign rword    = ram[widx];
  assign rshift   = rword >> {lane, 3'b000};

  // Byte-enable and zero-extended read data per width.
  always_comb begin
    be    = 4'b1111;
    rdata = rword;
    unique case (1'b1)
      is_byte: begin
        be    = 4'b0001 << lane;
        rdata = {24'd0, rshift[7:0]};
      end
      is_half: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        rdata = {16'd0, rshift[15:0]};
      end
      default: begin
        be    = 4'b1111;
        rdata = rword;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait countdown, re-arm and read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      armed     <= 1'b1;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_width <= 2'b00;
      req_wr    <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_addr  <= bus.address_main;
        req_wdata <= bus.write_data_main;
        req_width <= bus.width_main;
        req_wr    <= bus.write_request_main;
        cnt       <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !req_wr)
        data_q <= fault ? 32'd0 : rdata;
      if (!any_req)
        armed <= 1'b1;
      else if (state == DONE)
        armed <= 1'b0;
    end
  end

  // Storage write; a commit coinciding with reset still lands.
  always_ff @(posedge clk) begin
    if (commit && req_wr && !fault) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          ram[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
  end

  // Fetch port sees pre-write contents on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset)
      fetch_q <= 32'd0;
    else if (bus.fetch_request)
      fetch_q <= ram[fidx];
  end

  assign bus.busy_main  = (state == WAIT);
  assign bus.data_main  = data_q;
  assign bus.data_fetch = fetch_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (WAIT_CYCLES=2).
// Expected values are hand-computed per step.
module tb_data_memory_responder;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_memory_responder_if bus();

  data_memory_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic op(input  logic        wr,
                    input  logic [1:0]  w,
                    input  logic [31:0] a,
                    input  logic [31:0] wd,
                    output logic [31:0] rd,
                    output int          bc,
                    output logic        er,
                    output logic [31:0] fd);
    @(negedge clk);
    bus.address_main       = a;
    bus.width_main         = w;
    bus.write_data_main    = wd;
    bus.read_request_main  = !wr;
    bus.write_request_main = wr;
    bc = 0;
    @(negedge clk);
    while (bus.busy_main === 1'b1 && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    rd = bus.data_main;
    er = bus.error_main;
    fd = bus.data_fetch;
    bus.read_request_main  = 1'b0;
    bus.write_request_main = 1'b0;
  endtask

  logic [31:0] r;
  logic [31:0] f;
  logic        e;
  int          b;
  int          n;

  initial begin
    reset                  = 1'b1;
    bus.address_main       = 32'd0;
    bus.width_main         = 2'b00;
    bus.read_request_main  = 1'b0;
    bus.write_request_main = 1'b0;
    bus.write_data_main    = 32'd0;
    bus.address_fetch      = 32'd0;
    bus.fetch_request      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy_main), 32'd0);
    chk("rst_data", bus.data_main, 32'd0);
    chk("rst_err", 32'(bus.error_main), 32'd0);
    chk("rst_fetch", bus.data_fetch, 32'd0);

    op(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, r, b, e, f);
    chk("wr_busy", 32'(b), 32'd3);
    chk("wr_keep", r, 32'd0);
    chk("wr_err", 32'(e), 32'd0);
    op(1'b0, 2'b10, 32'h10, 32'd0, r, b, e, f);
    chk("rd_busy", 32'(b), 32'd3);
    chk("rd_data", r, 32'hDEADBEEF);

    @(negedge clk);
    bus.address_fetch = 32'h13;
    bus.fetch_request = 1'b1;
    op(1'b1, 2'b10, 32'h10, 32'h11111111, r, b, e, f);
    chk("fetch_old", f, 32'hDEADBEEF);
    chk("wr_keep2", r, 32'hDEADBEEF);
    @(negedge clk);
    chk("fetch_new", bus.data_fetch, 32'h11111111);
    bus.fetch_request = 1'b0;
    bus.address_fetch = 32'h0;
    repeat (2) @(negedge clk);
    chk("fetch_hold", bus.data_fetch, 32'h11111111);

    op(1'b1, 2'b10, 32'h10, 32'd0, r, b, e, f);
    op(1'b1, 2'b10, 32'h14, 32'd0, r, b, e, f);
    op(1'b1, 2'b00, 32'h11, 32'h5A5A55AA, r, b, e, f);
    op(1'b1, 2'b01, 32'h16, 32'hFFFF1234, r, b, e, f);
    op(1'b0, 2'b10, 32'h10, 32'd0, r, b, e, f);
    chk("lane_w10", r, 32'h0000AA00);
    op(1'b0, 2'b01, 32'h16, 32'd0, r, b, e, f);
    chk("lane_h16", r, 32'h00001234);
    op(1'b0, 2'b00, 32'h13, 32'd0, r, b, e, f);
    chk("lane_b13", r, 32'h00000000);
    op(1'b0, 2'b10, 32'h14, 32'd0, r, b, e, f);
    chk("lane_w14", r, 32'h12340000);
    op(1'b0, 2'b00, 32'h11, 32'd0, r, b, e, f);
    chk("lane_b11", r, 32'h000000AA);
    op(1'b0, 2'b01, 32'h10, 32'd0, r, b, e, f);
    chk("lane_h10", r, 32'h0000AA00);

    @(negedge clk);
    bus.address_main      = 32'h14;
    bus.width_main        = 2'b10;
    bus.read_request_main = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy_main === 1'b1) n++;
    end
    chk("hold_once", 32'(n), 32'd3);
    chk("hold_data", bus.data_main, 32'h12340000);
    bus.read_request_main = 1'b0;
    @(negedge clk);
    bus.read_request_main = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy_main === 1'b1) n++;
    end
    chk("rearm", 32'(n), 32'd3);
    bus.read_request_main = 1'b0;

    op(1'b1, 2'b10, 32'h0, 32'hCAFEF00D, r, b, e, f);
    op(1'b0, 2'b10, 32'h2, 32'd0, r, b, e, f);
`ifdef MEM_ERROR_EN
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_data", r, 32'd0);
    chk("mis_busy", 32'(b), 32'd3);
`else
    chk("mis_err", 32'(e), 32'd0);
    chk("mis_data", r, 32'hCAFEF00D);
`endif
    op(1'b0, 2'b10, 32'h1010, 32'd0, r, b, e, f);
`ifdef MEM_ERROR_EN
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_data", r, 32'd0);
`else
    chk("oor_wrap", r, 32'h0000AA00);
`endif
    op(1'b0, 2'b01, 32'h11, 32'd0, r, b, e, f);
`ifdef MEM_ERROR_EN
    chk("mish_err", 32'(e), 32'd1);
`else
    chk("mish_data", r, 32'h0000AA00);
`endif
    op(1'b1, 2'b10, 32'h6, 32'h0BADBAD0, r, b, e, f);
    op(1'b0, 2'b10, 32'h0, 32'd0, r, b, e, f);
`ifdef MEM_ERROR_EN
    chk("mis_ram", r, 32'hCAFEF00D);
`else
    chk("mis_wr", r, 32'hCAFEF00D);
`endif

    op(1'b1, 2'b10, 32'h20, 32'h01020304, r, b, e, f);
    @(negedge clk);
    bus.address_main       = 32'h20;
    bus.width_main         = 2'b10;
    bus.write_data_main    = 32'h55;
    bus.write_request_main = 1'b1;
    @(negedge clk);
    chk("mid_busy1", 32'(bus.busy_main), 32'd1);
    reset                  = 1'b1;
    bus.write_request_main = 1'b0;
    @(negedge clk);
    chk("mid_busy0", 32'(bus.busy_main), 32'd0);
    chk("mid_data", bus.data_main, 32'd0);
    reset = 1'b0;
    op(1'b0, 2'b10, 32'h20, 32'd0, r, b, e, f);
    chk("mid_ram", r, 32'h01020304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
